// File: rtl/ahb_lsu_master.sv
// AHB-Lite master for single core load/store transfers.
// Decodes slaves, tracks wait states, extends load data and traps errors.
module ahb_lsu_master #(
    parameter int                        NUM_SLAVES = 2,
    parameter logic [32*NUM_SLAVES-1:0]  SLV_BASE   = {32'hB000_0000, 32'hA000_0000},
    parameter logic [32*NUM_SLAVES-1:0]  SLV_MASK   = {32'hF000_0000, 32'hF000_0000},
    parameter int                        TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [2:0]                   req_func3,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic [31:0]                  haddr,
    output logic [1:0]                   htrans,
    output logic                         hwrite,
    output logic [2:0]                   hsize,
    output logic [31:0]                  hwdata,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [32*NUM_SLAVES-1:0]     hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state_q, state_d;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            f3_ok;
    logic            misal;
    logic            chk_ok;
    logic            s_ready;
    logic            s_resp;
    logic [31:0]     s_rdata;
    logic            timeout;
    logic [31:0]     rd_arr [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rd
        assign rd_arr[g] = hrdata_s[32*g +: 32];
    end

    assign s_ready = hreadyout_s[sel_q];
    assign s_resp  = hresp_s[sel_q];
    assign s_rdata = rd_arr[sel_q];
    assign timeout = !s_ready && (cnt_q == CW'(TIMEOUT - 1));

    function automatic logic [31:0] load_ext(
        input logic [2:0]  f3,
        input logic [1:0]  lane,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = w;
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = '0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [1:0]  sz,
        input logic [31:0] w
    );
        case (sz)
            2'b00:   store_lanes = {4{w[7:0]}};
            2'b01:   store_lanes = {2{w[15:0]}};
            default: store_lanes = w;
        endcase
    endfunction

    // Iterate downwards so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((req_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        if (req_write)
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misal  = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        chk_ok = hit && f3_ok && !misal;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        htrans    = 2'b00;
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = '0;
        hwdata    = '0;
        hsel      = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = chk_ok ? ADDR : RESP;
            end
            ADDR: begin
                htrans       = 2'b10;
                haddr        = addr_q;
                hwrite       = wr_q;
                hsize        = {1'b0, f3_q[1:0]};
                hsel[sel_q]  = 1'b1;
                state_d      = DATA;
            end
            DATA: begin
                haddr        = addr_q;
                hsel[sel_q]  = 1'b1;
                if (wr_q)
                    hwdata = store_lanes(f3_q[1:0], wdata_q);
                if (s_ready || timeout)
                    state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        f3_q    <= req_func3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        sel_q   <= hit_idx;
                        if (!chk_ok) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_ready) begin
                        err_q   <= s_resp;
                        rdata_q <= (wr_q || s_resp) ? '0
                                 : load_ext(f3_q, addr_q[1:0], s_rdata);
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Scoreboard bench for ahb_lsu_master with two behavioural AHB slaves.
// A byte-level reference memory predicts every response and bus phase.
module tb_ahb_lsu_master;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          bus;
        logic [2:0]  hsize;
        logic [1:0]  hsel;
        logic        wr;
        logic [31:0] hwdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  hsel;
    logic [63:0] hrdata_s;
    logic [1:0]  hreadyout_s;
    logic [1:0]  hresp_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t sbq[$];

    int   cfg_wait = 0;
    logic cfg_err  = 1'b0;

    logic [31:0] smem  [2][16];
    logic        s_dph [2];
    int          s_cnt [2];
    logic        s_err [2];
    logic [31:0] s_addr[2];
    logic        s_wr  [2];
    logic [2:0]  s_size[2];

    logic [7:0]  rmem  [2][64];

    ahb_lsu_master #(
        .NUM_SLAVES(2),
        .SLV_BASE({32'hB000_0000, 32'hA000_0000}),
        .SLV_MASK({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hsel(hsel),
        .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int s, input int i);
        if (s == 0 && i == 1)
            return 32'hDEAD_BEEF;
        return (32'h9E37_79B9 * 32'(s * 64 + i + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic lane_en(input logic [2:0] sz, input logic [1:0] a, input int j);
        if (sz == 3'b000) return (j == int'(a));
        if (sz == 3'b001) return ((j / 2) == int'(a[1]));
        return 1'b1;
    endfunction

    // Slave models: wait count and error flag latched at the address phase.
    for (genvar g = 0; g < 2; g++) begin : g_slv
        assign hreadyout_s[g]        = !(s_dph[g] && s_cnt[g] != 0);
        assign hresp_s[g]            = s_dph[g] && s_cnt[g] == 0 && s_err[g];
        assign hrdata_s[32*g +: 32]  = s_dph[g] ? smem[g][s_addr[g][5:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 16; i++)
                    smem[s][i] <= init_word(s, i);
                s_dph[s] <= 1'b0;
                s_cnt[s] <= 0;
                s_err[s] <= 1'b0;
                s_addr[s] <= '0;
                s_wr[s] <= 1'b0;
                s_size[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (s_dph[s]) begin
                    if (!hsel[s]) begin
                        s_dph[s] <= 1'b0;
                    end else if (s_cnt[s] != 0) begin
                        s_cnt[s] <= s_cnt[s] - 1;
                    end else begin
                        s_dph[s] <= 1'b0;
                        if (s_wr[s] && !s_err[s])
                            for (int j = 0; j < 4; j++)
                                if (lane_en(s_size[s], s_addr[s][1:0], j))
                                    smem[s][s_addr[s][5:2]][8*j +: 8] <= hwdata[8*j +: 8];
                    end
                end
                if (hsel[s] && htrans == 2'b10) begin
                    s_dph[s]  <= 1'b1;
                    s_cnt[s]  <= cfg_wait;
                    s_err[s]  <= cfg_err;
                    s_addr[s] <= haddr;
                    s_wr[s]   <= hwrite;
                    s_size[s] <= hsize;
                end
            end
        end
    end

    task automatic ref_init();
        logic [31:0] w;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) begin
                w = init_word(s, i);
                for (int b = 0; b < 4; b++)
                    rmem[s][4*i + b] = w[8*b +: 8];
            end
    endtask

    // Reference model: byte-addressed memory, region by top nibble.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits, input logic herr,
                         output exp_t e);
        int s, n, a;
        logic ok;
        logic [31:0] v;
        e.rdata = '0; e.err = 1'b0; e.cyc = 0; e.bus = 0;
        e.hsize = '0; e.hsel = '0; e.wr = wr; e.hwdata = '0;
        s = (addr[31:28] == 4'hA) ? 0 : (addr[31:28] == 4'hB) ? 1 : -1;
        n = 1 << f3[1:0];
        a = int'(addr[5:0]);
        ok = (s >= 0) &&
             (wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) &&
             ((int'(addr[1:0]) % n) == 0);
        if (!ok) begin
            e.err = 1'b1;
            e.cyc = 1;
        end else begin
            e.bus   = 1;
            e.hsize = {1'b0, f3[1:0]};
            e.hsel  = 2'(1 << s);
            for (int j = 0; j < 4; j++)
                e.hwdata[8*j +: 8] = wd[8*(j % n) +: 8];
            if (waits >= TIMEOUT) begin
                e.err = 1'b1;
                e.cyc = 2 + TIMEOUT;
            end else begin
                e.cyc = 3 + waits;
                if (herr) begin
                    e.err = 1'b1;
                end else if (wr) begin
                    for (int k = 0; k < n; k++)
                        rmem[s][a + k] = wd[8*k +: 8];
                end else begin
                    v = '0;
                    for (int k = 0; k < n; k++)
                        v[8*k +: 8] = rmem[s][a + k];
                    if (!f3[2] && n < 4 && v[8*n - 1])
                        for (int k = n; k < 4; k++)
                            v[8*k +: 8] = 8'hFF;
                    e.rdata = v;
                end
            end
        end
    endtask

    task automatic wait_ready();
        int b = 0;
        while (!req_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!req_ready)
            chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits, input logic herr);
        exp_t e;
        wait_ready();
        cfg_wait = waits;
        cfg_err  = herr;
        model(wr, f3, addr, wd, waits, herr, e);
        e.cyc = cyc + e.cyc;
        sbq.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: records address/data phases, checks each response pulse.
    int          nseq = 0;
    logic [2:0]  b_size;
    logic [1:0]  b_sel;
    logic        b_wr;
    logic [31:0] b_wdata;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            nseq = 0;
        end else begin
            if (htrans == 2'b10) begin
                nseq++;
                b_size = hsize;
                b_sel  = hsel;
                b_wr   = hwrite;
            end
            if (htrans == 2'b00 && hsel != 2'b00)
                b_wdata = hwdata;
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("bus_nonseq", 32'(nseq), 32'(e.bus));
                    chk("hsel_resp", 32'(hsel), 32'd0);
                    if (e.bus != 0) begin
                        chk("hsize", 32'(b_size), 32'(e.hsize));
                        chk("hsel", 32'(b_sel), 32'(e.hsel));
                        chk("hwrite", 32'(b_wr), 32'(e.wr));
                        if (e.wr)
                            chk("hwdata", b_wdata, e.hwdata);
                    end
                end
                nseq = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_hsel"}, 32'(hsel), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] tmp, addr, wd;
        logic [3:0]  rg;
        logic [2:0]  f3;
        logic        wr, herr;
        int          waits, r, b;

        ref_init();
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("in_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        issue(1'b0, 3'b010, 32'hA000_0004, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b010, 32'hB000_0008, 32'h1234_5678, 0, 1'b0);
        issue(1'b0, 3'b000, 32'hB000_000B, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b000, 32'hB000_0009, 32'h0000_0080, 0, 1'b0);
        issue(1'b0, 3'b000, 32'hB000_0009, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b100, 32'hB000_0009, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b000, 32'hB000_0001, 32'h0000_00AB, 0, 1'b0);
        issue(1'b1, 3'b001, 32'hB000_0002, 32'h0000_CAFE, 0, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_0000, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b001, 32'hB000_0006, 32'h0000_8001, 1, 1'b0);
        issue(1'b0, 3'b001, 32'hB000_0006, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b101, 32'hB000_0006, 32'h0, 2, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_0002, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'hC000_0000, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b011, 32'hB000_0000, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b100, 32'hB000_0000, 32'h0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_0008, 32'h0, 3, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_000C, 32'h0, TIMEOUT - 1, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_0004, 32'h0, TIMEOUT, 1'b0);
        issue(1'b0, 3'b010, 32'hB000_0004, 32'h0, 0, 1'b1);
        issue(1'b1, 3'b010, 32'hB000_0010, 32'hFEED_F00D, 1, 1'b1);
        issue(1'b0, 3'b010, 32'hB000_0010, 32'h0, 0, 1'b0);

        // Reset in the middle of a data phase: nothing is pushed for it.
        wait_ready();
        cfg_wait  = 6;
        cfg_err   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'hB000_0014;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_hsel", 32'(hsel), 32'd2);
        reset = 1'b1;
        #1 check_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        ref_init();
        @(negedge clk);
        check_idle_outputs("post_reset");
        issue(1'b0, 3'b010, 32'hA000_0004, 32'h0, 0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 9);
            rg = (r < 4) ? 4'hA : (r < 9) ? 4'hB : 4'hC;
            tmp  = $urandom();
            addr = {rg, tmp[27:0]};
            wd   = $urandom();
            wr   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) != 0) begin
                r = $urandom_range(0, wr ? 2 : 4);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) < 85) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            r = $urandom_range(0, 9);
            waits = (r < 8) ? $urandom_range(0, 3)
                  : (r < 9) ? $urandom_range(4, 8)
                  : $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            herr = ($urandom_range(0, 19) == 0);
            issue(wr, f3, addr, wd, waits, herr);
        end

        b = 0;
        while (sbq.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (sbq.size() != 0)
            chk("drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
